// File: rtl/display_ctrl_fsm.sv
// Display-sequencing controller: clears the frame, waits for a start press/release, then on each beat
// runs a load/draw handshake with the shape drawer for every lane enabled in boxMask. Optional: SHAPE_TIMEOUT_EN.
module display_ctrl_fsm #(
    parameter int GRID_W         = 240,
    parameter int GRID_H         = 180,
    parameter int NUM_BOXES      = 3,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int NPIX = GRID_W * GRID_H,
    localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1,
    localparam int BW   = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 beatIncremented,
    input  logic                 songDone,
    input  logic                 shapeDone,
    input  logic [NUM_BOXES-1:0] boxMask,
    output logic                 loadDefault,
    output logic                 writeDefault,
    output logic                 readyForSong,
    output logic                 loadStartAddress,
    output logic                 startingAddressLoaded,
    output logic [CW-1:0]        gridCounter,
    output logic [BW-1:0]        boxIndex,
    output logic                 missedBeat,
    output logic                 shapeTimeout,
    output logic [3:0]           currentState
);

    typedef enum logic [3:0] {
        S_IDLE          = 4'd0,
        S_LOAD_DEFAULT  = 4'd1,
        S_WRITE_DEFAULT = 4'd2,
        S_START         = 4'd3,
        S_START_WAIT    = 4'd4,
        S_WAIT_SONG     = 4'd5,
        S_SELECT_BOX    = 4'd6,
        S_LOAD_BOX      = 4'd7,
        S_DRAW          = 4'd8,
        S_WAIT_SHAPE    = 4'd9
    } state_t;

    localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);
    localparam logic [BW-1:0] LAST_BOX = BW'(NUM_BOXES - 1);

    state_t                 state, state_next;
    logic [CW-1:0]          grid_next;
    logic [BW-1:0]          box_next;
    logic [NUM_BOXES-1:0]   pend_mask, pend_mask_next;
    logic                   song_pending, song_pending_next;
    logic                   busy;
    logic                   expire;
    state_t                 end_state;

    assign currentState = state;
    assign busy = (state == S_SELECT_BOX) || (state == S_LOAD_BOX) ||
                  (state == S_DRAW) || (state == S_WAIT_SHAPE);
    // A song end seen on the very cycle a beat finishes still counts for that beat.
    assign end_state = (song_pending || songDone) ? S_IDLE : S_WAIT_SONG;

    // TIMEOUT_CYCLES only has an effect when the shape timeout is built in.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg_unused
    end

`ifdef SHAPE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_count;

    assign expire = (state == S_WAIT_SHAPE) && (wait_count == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_count   <= '0;
            shapeTimeout <= 1'b0;
        end else begin
            if (state != S_WAIT_SHAPE) wait_count <= '0;
            else                       wait_count <= wait_count + TW'(1);
            shapeTimeout <= expire && !shapeDone;
        end
    end
`else
    assign expire       = 1'b0;
    assign shapeTimeout = 1'b0;
`endif

    always_comb begin
        state_next            = state;
        grid_next             = gridCounter;
        box_next              = boxIndex;
        pend_mask_next        = pend_mask;
        song_pending_next     = song_pending | (songDone && (state != S_WAIT_SONG));
        loadDefault           = 1'b0;
        writeDefault          = 1'b0;
        readyForSong          = 1'b0;
        loadStartAddress      = 1'b0;
        startingAddressLoaded = 1'b0;
        case (state)
            S_IDLE: begin
                grid_next         = '0;
                song_pending_next = 1'b0;
                state_next        = S_LOAD_DEFAULT;
            end
            S_LOAD_DEFAULT: begin
                loadDefault = 1'b1;
                state_next  = S_WRITE_DEFAULT;
            end
            S_WRITE_DEFAULT: begin
                writeDefault = 1'b1;
                if (gridCounter == LAST_PIX) begin
                    state_next = S_START;
                end else begin
                    grid_next  = gridCounter + CW'(1);
                    state_next = S_LOAD_DEFAULT;
                end
            end
            S_START: begin
                if (start) state_next = S_START_WAIT;
            end
            S_START_WAIT: begin
                if (!start) state_next = S_WAIT_SONG;
            end
            S_WAIT_SONG: begin
                readyForSong = 1'b1;
                if (songDone) begin
                    state_next = S_IDLE;
                end else if (beatIncremented) begin
                    pend_mask_next = boxMask;
                    box_next       = '0;
                    state_next     = S_SELECT_BOX;
                end
            end
            S_SELECT_BOX: begin
                if (pend_mask[boxIndex]) begin
                    state_next = S_LOAD_BOX;
                end else if (boxIndex == LAST_BOX) begin
                    state_next = end_state;
                end else begin
                    box_next = boxIndex + BW'(1);
                end
            end
            S_LOAD_BOX: begin
                loadStartAddress = 1'b1;
                state_next       = S_DRAW;
            end
            S_DRAW: begin
                startingAddressLoaded = 1'b1;
                state_next            = S_WAIT_SHAPE;
            end
            S_WAIT_SHAPE: begin
                if (shapeDone || expire) begin
                    if (boxIndex == LAST_BOX) begin
                        state_next = end_state;
                    end else begin
                        box_next   = boxIndex + BW'(1);
                        state_next = S_SELECT_BOX;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            gridCounter  <= '0;
            boxIndex     <= '0;
            pend_mask    <= '0;
            song_pending <= 1'b0;
            missedBeat   <= 1'b0;
        end else begin
            state        <= state_next;
            gridCounter  <= grid_next;
            boxIndex     <= box_next;
            pend_mask    <= pend_mask_next;
            song_pending <= song_pending_next;
            missedBeat   <= beatIncremented && busy;
        end
    end

endmodule

// File: tb/tb_display_ctrl_fsm.sv
// Bench for display_ctrl_fsm on a 4x2 grid with 3 lanes; strobe events are matched in order against exp_q.
module tb_display_ctrl_fsm;

    localparam logic [3:0]  EV_WRITE   = 4'd1;
    localparam logic [3:0]  EV_LOAD    = 4'd2;
    localparam logic [3:0]  EV_DRAW    = 4'd3;
    localparam logic [3:0]  EV_MISSED  = 4'd4;
    localparam logic [3:0]  EV_TIMEOUT = 4'd5;
    localparam logic [15:0] NO_EVENT   = 16'hFFFF;

    logic       clock = 1'b0;
    logic       reset;
    logic       start, beatIncremented, songDone, shapeDone;
    logic [2:0] boxMask;
    logic       loadDefault, writeDefault, readyForSong, loadStartAddress, startingAddressLoaded;
    logic [2:0] gridCounter;
    logic [1:0] boxIndex;
    logic       missedBeat, shapeTimeout;
    logic [3:0] currentState;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    display_ctrl_fsm #(.GRID_W(4), .GRID_H(2), .NUM_BOXES(3), .TIMEOUT_CYCLES(16)) dut (
        .clock(clock), .reset(reset), .start(start), .beatIncremented(beatIncremented),
        .songDone(songDone), .shapeDone(shapeDone), .boxMask(boxMask),
        .loadDefault(loadDefault), .writeDefault(writeDefault), .readyForSong(readyForSong),
        .loadStartAddress(loadStartAddress), .startingAddressLoaded(startingAddressLoaded),
        .gridCounter(gridCounter), .boxIndex(boxIndex), .missedBeat(missedBeat),
        .shapeTimeout(shapeTimeout), .currentState(currentState)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] ev(input logic [3:0] kind, input logic [11:0] val);
        return {kind, val};
    endfunction

    function automatic logic [11:0] outs_vec();
        return {loadDefault, writeDefault, readyForSong, loadStartAddress, startingAddressLoaded,
                missedBeat, shapeTimeout, gridCounter, boxIndex};
    endfunction

    // scoreboard
    task automatic observe(input logic [15:0] got);
        logic [15:0] want;
        if (exp_q.size() == 0) want = NO_EVENT;
        else                   want = exp_q.pop_front();
        check("event", {16'd0, got}, {16'd0, want});
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (writeDefault)          observe(ev(EV_WRITE, 12'(gridCounter)));
            if (loadStartAddress)      observe(ev(EV_LOAD, 12'(boxIndex)));
            if (startingAddressLoaded) observe(ev(EV_DRAW, 12'(boxIndex)));
            if (missedBeat)            observe(ev(EV_MISSED, 12'd0));
            if (shapeTimeout)          observe(ev(EV_TIMEOUT, 12'(boxIndex)));
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_clear();
        for (int i = 0; i < 8; i++) exp_q.push_back(ev(EV_WRITE, 12'(i)));
    endtask

    task automatic push_box(input int b);
        exp_q.push_back(ev(EV_LOAD, 12'(b)));
        exp_q.push_back(ev(EV_DRAW, 12'(b)));
    endtask

    task automatic wait_state(input logic [3:0] s, input int limit, input string tag);
        for (int i = 0; i < limit; i++) begin
            if (currentState == s) break;
            step(1);
        end
        check(tag, currentState, s);
    endtask

    task automatic wait_kick(input int limit);
        for (int i = 0; i < limit; i++) begin
            step(1);
            if (startingAddressLoaded) break;
        end
        check("kick_seen", startingAddressLoaded, 1);
    endtask

    task automatic pulse_done();
        shapeDone = 1'b1;
        step(1);
        shapeDone = 1'b0;
    endtask

    task automatic serve_box(input int delay);
        wait_kick(20);
        step(delay);
        pulse_done();
    endtask

    task automatic beat(input logic [2:0] mask);
        boxMask         = mask;
        beatIncremented = 1'b1;
        step(1);
        beatIncremented = 1'b0;
        boxMask         = 3'b000;
    endtask

    task automatic press_start(input int hold);
        start = 1'b1;
        step(hold);
        start = 1'b0;
        step(1);
        check("start_release_wait_song", currentState, 5);
        check("ready_for_song", readyForSong, 1);
    endtask

    initial begin
        int sel_cycles;
        reset = 1'b1; start = 1'b0; beatIncremented = 1'b0;
        songDone = 1'b0; shapeDone = 1'b0; boxMask = 3'b000;
        step(2);
        check("reset_state", currentState, 0);
        check("reset_outputs", outs_vec(), 0);

        // clear after reset release
        push_clear();
        reset = 1'b0;
        step(1);
        check("first_edge_load_default", currentState, 1);
        step(15);
        check("last_pixel_write", currentState, 2);
        check("last_pixel_addr", gridCounter, 7);
        step(1);
        check("start_at_cycle_17", currentState, 3);

        // start press with a stray beat (ignored), held 5 cycles
        start = 1'b1; beatIncremented = 1'b1;
        step(1);
        beatIncremented = 1'b0;
        check("start_wait", currentState, 4);
        step(4);
        check("still_start_wait", currentState, 4);
        start = 1'b0;
        step(1);
        check("wait_song_after_release", currentState, 5);
        check("ready_for_song_1", readyForSong, 1);

        // mask 101
        push_box(0); push_box(2);
        beat(3'b101);
        check("select_after_beat", currentState, 6);
        step(1);
        check("beat_to_load_2cyc", loadStartAddress, 1);
        check("load_box0_index", boxIndex, 0);
        serve_box(4);
        check("select_after_done", currentState, 6);
        check("select_box1", boxIndex, 1);
        serve_box(4);
        check("mask101_back_wait", currentState, 5);

        // deferred song end plus missed beat, mask 111
        push_box(0); push_box(1);
        exp_q.push_back(ev(EV_MISSED, 12'd0));
        push_box(2); push_clear();
        beat(3'b111);
        serve_box(4);
        wait_kick(20);
        step(1);
        songDone = 1'b1; beatIncremented = 1'b1;
        step(1);
        songDone = 1'b0; beatIncremented = 1'b0;
        check("missed_beat_pulse", missedBeat, 1);
        step(1);
        check("missed_beat_one_cycle", missedBeat, 0);
        check("box1_still_waiting", currentState, 9);
        step(1);
        pulse_done();
        serve_box(4);
        check("deferred_end_idle", currentState, 0);
        step(16);
        check("reclear_last_write", currentState, 2);
        step(1);
        check("reclear_start", currentState, 3);
        press_start(3);

        // songDone beats beatIncremented in WAIT_SONG
        push_clear();
        songDone = 1'b1; boxMask = 3'b111; beatIncremented = 1'b1;
        step(1);
        songDone = 1'b0; boxMask = 3'b000; beatIncremented = 1'b0;
        check("songdone_priority", currentState, 0);
        wait_state(3, 40, "clear_after_song");
        press_start(2);

`ifdef SHAPE_TIMEOUT_EN
        // no shapeDone on box 0: timeout advances to box 1
        push_box(0);
        exp_q.push_back(ev(EV_TIMEOUT, 12'd1));
        push_box(1);
        beat(3'b011);
        wait_kick(20);
        step(16);
        check("timeout_not_yet", shapeTimeout, 0);
        check("timeout_still_waiting", currentState, 9);
        step(1);
        check("timeout_pulse", shapeTimeout, 1);
        check("timeout_next_select", currentState, 6);
        check("timeout_next_box", boxIndex, 1);
        serve_box(4);
        check("timeout_back_wait", currentState, 5);
`endif

        // reset in DRAW
        exp_q.push_back(ev(EV_LOAD, 12'd1));
        beat(3'b010);
        wait_state(8, 10, "reach_draw");
        reset = 1'b1;
        #1;
        check("async_reset_state", currentState, 0);
        check("async_reset_outputs", outs_vec(), 0);
        step(2);
        push_clear();
        reset = 1'b0;
        wait_state(3, 40, "clear_after_reset");
        press_start(1);

        // mask 0: three SELECT_BOX cycles, no draws
        beat(3'b000);
        sel_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (currentState != 6) break;
            sel_cycles++;
            step(1);
        end
        check("mask0_select_cycles", sel_cycles, 3);
        check("mask0_back_wait", currentState, 5);

        // shapeDone outside WAIT_SHAPE is ignored
        pulse_done();
        check("stray_done_ignored", currentState, 5);

        step(3);
        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_ctrl_fsm.md
# display_ctrl_fsm

Parametrised display-sequencing controller for the note-highway display path. After reset or a finished song it clears a GRID_W×GRID_H frame to the default colour, waits for a start press/release, and then on every beat issues a load/draw handshake to the shape drawer for each enabled lane box. It replaces the fixed 3-box, fixed-grid controller and adds:

- a per-beat lane mask;
- exact-length clear and box loops;
- deferred song-end handling;
- beat-overrun reporting;
- an optional shape-done timeout.

## Interface
Parameters:
- GRID_W, 240, frame width in pixels
- GRID_H, 180, frame height in pixels
- NUM_BOXES, 3, lane boxes per beat (≥1)
- TIMEOUT_CYCLES, 1024, WAIT_SHAPE timeout limit (used only with SHAPE_TIMEOUT_EN)
- Derived: CW = $clog2(GRID_W*GRID_H); BW = max(1, $clog2(NUM_BOXES))

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  start button level
- beatIncremented  in  1  one-cycle beat pulse
- songDone  in  1  one-cycle song-end pulse
- shapeDone  in  1  one-cycle pulse from shape drawer
- boxMask  in  NUM_BOXES  lanes to draw; sampled on the accepted beat
- loadDefault  out  1  clear: load default pixel
- writeDefault  out  1  clear: write pixel at gridCounter
- readyForSong  out  1  idle between beats
- loadStartAddress  out  1  load start address of box boxIndex
- startingAddressLoaded  out  1  one-cycle draw kick
- gridCounter  out  CW  clear pixel address
- boxIndex  out  BW  current box
- missedBeat  out  1  one-cycle pulse: beat arrived while busy
- shapeTimeout  out  1  one-cycle pulse: shape abandoned
- currentState  out  4  state code, debug

## Operation
State codes and transitions:
- IDLE(0): gridCounter←0, songPending←0 → LOAD_DEFAULT
- LOAD_DEFAULT(1): loadDefault=1 → WRITE_DEFAULT
- WRITE_DEFAULT(2): writeDefault=1
  - gridCounter==GRID_W*GRID_H−1 → START
  - else gridCounter+1 → LOAD_DEFAULT
- START(3): start=1 → START_WAIT
- START_WAIT(4): start=0 → WAIT_SONG (press then release)
- WAIT_SONG(5): readyForSong=1
  - songDone → IDLE (priority over beat)
  - else beatIncremented: pendMask←boxMask, boxIndex←0 → SELECT_BOX
- SELECT_BOX(6):
  - pendMask[boxIndex]=1 → LOAD_BOX
  - else boxIndex==NUM_BOXES−1 → END
  - else boxIndex+1, stay
- LOAD_BOX(7): loadStartAddress=1 → DRAW
- DRAW(8): startingAddressLoaded=1 → WAIT_SHAPE
- WAIT_SHAPE(9): shapeDone (or timeout)
  - boxIndex==NUM_BOXES−1 → END
  - else boxIndex+1 → SELECT_BOX
- END is the decision made in that cycle, not a separate state:
  - songPending → IDLE
  - else → WAIT_SONG
- Codes 10–15 → IDLE.

Rules:
- Outputs loadDefault…startingAddressLoaded and readyForSong are Moore decodes of the state.
- missedBeat and shapeTimeout are registered.
- songDone outside WAIT_SONG sets songPending. The current beat finishes, then the FSM goes to IDLE; the clear follows.
- beatIncremented in states 6–9 is dropped and pulses missedBeat the next cycle.
- beatIncremented in states 0–4 is ignored silently.
- A beat with boxMask=0 walks SELECT_BOX NUM_BOXES cycles, then returns to WAIT_SONG with no draw pulses.
- shapeDone outside WAIT_SHAPE is ignored.
- Arithmetic: counters are unsigned. gridCounter never exceeds GRID_W*GRID_H−1. boxIndex never exceeds NUM_BOXES−1, so there is no wrap.

## Timing
- Reset value of every output and internal register (state, counters, pendMask, songPending): 0, i.e. state IDLE with all strobes low.
- Asserting reset mid-operation aborts immediately with no handshake completion. After reset releases, the first edge enters LOAD_DEFAULT.
- Clear: 2 cycles per pixel.
  - IDLE to first START cycle = 1 + 2·GRID_W·GRID_H cycles.
- Beat accept to first loadStartAddress = 2 cycles when box 0 is enabled. Each skipped box adds 1 cycle.
- startingAddressLoaded is high exactly 1 cycle, the cycle after loadStartAddress.
- shapeDone seen in WAIT_SHAPE leaves the state on the next edge. The next box's SELECT_BOX follows 1 cycle later.

## Configuration
- SHAPE_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT_SHAPE.
  - If TIMEOUT_CYCLES cycles pass with no shapeDone, the FSM leaves WAIT_SHAPE as if done.
  - shapeTimeout pulses 1 cycle.
  - shapeDone in the same cycle as expiry takes priority, with no shapeTimeout pulse.
- Undefined: shapeTimeout is tied 0, no counter logic exists, and WAIT_SHAPE waits indefinitely.

## Test plan
All scenarios use GRID_W=4, GRID_H=2, NUM_BOXES=3.
- Clear after reset release → exactly 8 writeDefault pulses with gridCounter 0..7, then START at cycle 17.
- Start held 5 cycles then released → WAIT_SONG 1 cycle after release. readyForSong=1.
- Beat with boxMask=3'b101, shapeDone 4 cycles after each kick → load/draw pairs at boxIndex 0 and 2 only, then WAIT_SONG.
- songDone during WAIT_SHAPE of box 1, mask 3'b111 → box 2 still drawn, then IDLE and a fresh 8-pixel clear. beatIncremented during box 1 → missedBeat one pulse.
- With SHAPE_TIMEOUT_EN, TIMEOUT_CYCLES=16, and no shapeDone → shapeTimeout pulse 16 cycles after entering WAIT_SHAPE, and the FSM advances to the next box.
- Reset asserted in DRAW → all outputs 0 asynchronously, state 0. Mask 0 beat → 3 SELECT_BOX cycles, no loadStartAddress.
